cache_port_sched: RTL and testbench

- Request scheduler between two requesters and the simple cache's three ports: read p1, read p2 and write p1.
- Requester A is instruction fetch, read-only, and is routed to read port p1.
- Requester B is load/store; its reads go to read port p2 and its writes go to write port p1.
- Per path: sequences each cache access, retries misses up to a bound, and blocks read/write hazards on the same cache line between the two paths.

---
 rtl/cache_port_sched.sv | 222 ++++++++++++++++++++++
 tb/tb_cache_port_sched.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_port_sched.sv
// Request scheduler between two requesters and the cache's read p1, read p2
// and write p1 ports. Path A (instruction fetch) reads through p1; path B
// (load/store) reads through p2 and writes through write p1. Each path issues
// one access at a time, retries misses up to MAX_RETRY times, and same-line
// write hazards between the paths are blocked at the request handshake.
module cache_port_sched #(
    parameter int ADDR_LENTH  = 32,
    parameter int LINE_SIZE   = 128,
    parameter int OFFSET_BITS = 4,
    parameter int MAX_RETRY   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    // requester A: read-only
    input  logic                  a_req_valid,
    output logic                  a_req_ready,
    input  logic [ADDR_LENTH-1:0] a_req_addr,
    output logic                  a_rsp_valid,
    output logic [LINE_SIZE-1:0]  a_rsp_data,
    output logic                  a_rsp_err,
    // requester B: read/write
    input  logic                  b_req_valid,
    output logic                  b_req_ready,
    input  logic                  b_req_we,
    input  logic [ADDR_LENTH-1:0] b_req_addr,
    input  logic [LINE_SIZE-1:0]  b_req_wdata,
    output logic                  b_rsp_valid,
    output logic [LINE_SIZE-1:0]  b_rsp_data,
    output logic                  b_rsp_err,
    // cache read port p1
    output logic                  re_p1_i,
    output logic [ADDR_LENTH-1:0] raddr_p1_i,
    input  logic [LINE_SIZE-1:0]  rdata_p1_o,
    input  logic                  read_hit_p1_o,
    // cache read port p2
    output logic                  re_p2_i,
    output logic [ADDR_LENTH-1:0] raddr_p2_i,
    input  logic [LINE_SIZE-1:0]  rdata_p2_o,
    input  logic                  read_hit_p2_o,
    // cache write port p1
    output logic                  we_p1_i,
    output logic [ADDR_LENTH-1:0] waddr_p1_i,
    output logic [LINE_SIZE-1:0]  wdata_p1_i,
    input  logic                  write_hit_p1_o
);

    localparam int RW     = $clog2(MAX_RETRY + 1);
    localparam int LINE_W = ADDR_LENTH - OFFSET_BITS;
    localparam logic [RW-1:0] MAX_R = RW'(MAX_RETRY);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

    state_t                a_state_q, a_state_d, b_state_q, b_state_d;
    logic [RW-1:0]         a_retry_q, a_retry_d, b_retry_q, b_retry_d;
    logic                  a_rsp_valid_q, a_rsp_valid_d, a_rsp_err_q, a_rsp_err_d;
    logic                  b_rsp_valid_q, b_rsp_valid_d, b_rsp_err_q, b_rsp_err_d;
    logic [LINE_SIZE-1:0]  a_rsp_data_q, a_rsp_data_d, b_rsp_data_q, b_rsp_data_d;
    logic                  re_p1_q, re_p2_q, we_p1_q, b_we_q, b_we_d;
    logic [ADDR_LENTH-1:0] raddr_p1_q, raddr_p2_q, waddr_p1_q;
    logic [LINE_SIZE-1:0]  wdata_p1_q;
    logic                  a_idle, b_idle, haz_a, haz_b, a_accept, b_accept, b_hit;
    logic [LINE_W-1:0]     a_req_line, b_req_line, a_cap_line, b_cap_line;

    // The port address/data registers double as the capture registers, so
    // the in-flight line of each path is read straight from them.
    assign a_req_line = a_req_addr[ADDR_LENTH-1:OFFSET_BITS];
    assign b_req_line = b_req_addr[ADDR_LENTH-1:OFFSET_BITS];
    assign a_cap_line = raddr_p1_q[ADDR_LENTH-1:OFFSET_BITS];
    assign b_cap_line = waddr_p1_q[ADDR_LENTH-1:OFFSET_BITS];

    assign a_idle = (a_state_q == S_IDLE);
    assign b_idle = (b_state_q == S_IDLE);

    // A pending B write to the same line wins over a simultaneous A read.
    assign haz_a = (!b_idle && b_we_q && (b_cap_line == a_req_line)) ||
                   (b_idle && b_req_valid && b_req_we && (b_req_line == a_req_line));
    assign haz_b = b_req_we && !a_idle && (a_cap_line == b_req_line);

    assign a_req_ready = a_idle && !haz_a;
    assign b_req_ready = b_idle && !haz_b;
    assign a_accept    = a_req_valid && a_req_ready;
    assign b_accept    = b_req_valid && b_req_ready;

    assign b_hit  = b_we_q ? write_hit_p1_o : read_hit_p2_o;
    assign b_we_d = b_accept ? b_req_we : b_we_q;

    // Path A next state, retry count and response
    always_comb begin
        a_state_d     = a_state_q;
        a_retry_d     = a_retry_q;
        a_rsp_valid_d = 1'b0;
        a_rsp_data_d  = '0;
        a_rsp_err_d   = 1'b0;
        case (a_state_q)
            S_IDLE: begin
                if (a_accept) begin
                    a_state_d = S_ISSUE;
                    a_retry_d = '0;
                end
            end
            S_ISSUE: a_state_d = S_WAIT;
            S_WAIT: begin
                if (read_hit_p1_o) begin
                    a_rsp_valid_d = 1'b1;
                    a_rsp_data_d  = rdata_p1_o;
                    a_state_d     = S_IDLE;
                end else if (a_retry_q < MAX_R) begin
                    a_retry_d = a_retry_q + RW'(1);
                    a_state_d = S_ISSUE;
                end else begin
                    a_rsp_valid_d = 1'b1;
                    a_rsp_err_d   = 1'b1;
                    a_state_d     = S_IDLE;
                end
            end
            default: a_state_d = S_IDLE;
        endcase
    end

    // Path B next state, retry count and response
    always_comb begin
        b_state_d     = b_state_q;
        b_retry_d     = b_retry_q;
        b_rsp_valid_d = 1'b0;
        b_rsp_data_d  = '0;
        b_rsp_err_d   = 1'b0;
        case (b_state_q)
            S_IDLE: begin
                if (b_accept) begin
                    b_state_d = S_ISSUE;
                    b_retry_d = '0;
                end
            end
            S_ISSUE: b_state_d = S_WAIT;
            S_WAIT: begin
                if (b_hit) begin
                    b_rsp_valid_d = 1'b1;
                    b_rsp_data_d  = b_we_q ? '0 : rdata_p2_o;
                    b_state_d     = S_IDLE;
                end else if (b_retry_q < MAX_R) begin
                    b_retry_d = b_retry_q + RW'(1);
                    b_state_d = S_ISSUE;
                end else begin
                    b_rsp_valid_d = 1'b1;
                    b_rsp_err_d   = 1'b1;
                    b_state_d     = S_IDLE;
                end
            end
            default: b_state_d = S_IDLE;
        endcase
    end

    // Path A registers: state, port p1 strobe/address, response
    always_ff @(posedge clk) begin
        if (rst) begin
            a_state_q     <= S_IDLE;
            a_retry_q     <= '0;
            re_p1_q       <= 1'b0;
            raddr_p1_q    <= '0;
            a_rsp_valid_q <= 1'b0;
            a_rsp_data_q  <= '0;
            a_rsp_err_q   <= 1'b0;
        end else begin
            a_state_q     <= a_state_d;
            a_retry_q     <= a_retry_d;
            re_p1_q       <= (a_state_d == S_ISSUE);
            if (a_accept) raddr_p1_q <= a_req_addr;
            a_rsp_valid_q <= a_rsp_valid_d;
            a_rsp_data_q  <= a_rsp_data_d;
            a_rsp_err_q   <= a_rsp_err_d;
        end
    end

    // Path B registers: state, captured direction, read p2 / write p1 ports, response
    always_ff @(posedge clk) begin
        if (rst) begin
            b_state_q     <= S_IDLE;
            b_retry_q     <= '0;
            b_we_q        <= 1'b0;
            re_p2_q       <= 1'b0;
            we_p1_q       <= 1'b0;
            raddr_p2_q    <= '0;
            waddr_p1_q    <= '0;
            wdata_p1_q    <= '0;
            b_rsp_valid_q <= 1'b0;
            b_rsp_data_q  <= '0;
            b_rsp_err_q   <= 1'b0;
        end else begin
            b_state_q <= b_state_d;
            b_retry_q <= b_retry_d;
            b_we_q    <= b_we_d;
            re_p2_q   <= (b_state_d == S_ISSUE) && !b_we_d;
            we_p1_q   <= (b_state_d == S_ISSUE) && b_we_d;
            if (b_accept) begin
                if (b_req_we) begin
                    waddr_p1_q <= b_req_addr;
                    wdata_p1_q <= b_req_wdata;
                end else begin
                    raddr_p2_q <= b_req_addr;
                end
            end
            b_rsp_valid_q <= b_rsp_valid_d;
            b_rsp_data_q  <= b_rsp_data_d;
            b_rsp_err_q   <= b_rsp_err_d;
        end
    end

    assign re_p1_i     = re_p1_q;
    assign raddr_p1_i  = raddr_p1_q;
    assign re_p2_i     = re_p2_q;
    assign raddr_p2_i  = raddr_p2_q;
    assign we_p1_i     = we_p1_q;
    assign waddr_p1_i  = waddr_p1_q;
    assign wdata_p1_i  = wdata_p1_q;
    assign a_rsp_valid = a_rsp_valid_q;
    assign a_rsp_data  = a_rsp_data_q;
    assign a_rsp_err   = a_rsp_err_q;
    assign b_rsp_valid = b_rsp_valid_q;
    assign b_rsp_data  = b_rsp_data_q;
    assign b_rsp_err   = b_rsp_err_q;

endmodule

// File: tb/tb_cache_port_sched.sv
// Bench for cache_port_sched: transaction-level reference model (accept cycle,
// planned miss count, derived strobe/response cycles) plus a cache model that
// answers each expected strobe; directed scenarios followed by random traffic.
module tb_cache_port_sched;

    localparam int AW = 32;
    localparam int LW = 128;
    localparam int OB = 4;
    localparam int MR = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          a_req_valid, a_req_ready, a_rsp_valid, a_rsp_err;
    logic [AW-1:0] a_req_addr;
    logic [LW-1:0] a_rsp_data;
    logic          b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_err;
    logic [AW-1:0] b_req_addr;
    logic [LW-1:0] b_req_wdata, b_rsp_data;
    logic          re_p1_i, read_hit_p1_o, re_p2_i, read_hit_p2_o, we_p1_i, write_hit_p1_o;
    logic [AW-1:0] raddr_p1_i, raddr_p2_i, waddr_p1_i;
    logic [LW-1:0] rdata_p1_o, rdata_p2_o, wdata_p1_i;

    always #5 clk = ~clk;

    cache_port_sched #(
        .ADDR_LENTH (AW),
        .LINE_SIZE  (LW),
        .OFFSET_BITS(OB),
        .MAX_RETRY  (MR)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .a_req_valid   (a_req_valid),
        .a_req_ready   (a_req_ready),
        .a_req_addr    (a_req_addr),
        .a_rsp_valid   (a_rsp_valid),
        .a_rsp_data    (a_rsp_data),
        .a_rsp_err     (a_rsp_err),
        .b_req_valid   (b_req_valid),
        .b_req_ready   (b_req_ready),
        .b_req_we      (b_req_we),
        .b_req_addr    (b_req_addr),
        .b_req_wdata   (b_req_wdata),
        .b_rsp_valid   (b_rsp_valid),
        .b_rsp_data    (b_rsp_data),
        .b_rsp_err     (b_rsp_err),
        .re_p1_i       (re_p1_i),
        .raddr_p1_i    (raddr_p1_i),
        .rdata_p1_o    (rdata_p1_o),
        .read_hit_p1_o (read_hit_p1_o),
        .re_p2_i       (re_p2_i),
        .raddr_p2_i    (raddr_p2_i),
        .rdata_p2_o    (rdata_p2_o),
        .read_hit_p2_o (read_hit_p2_o),
        .we_p1_i       (we_p1_i),
        .waddr_p1_i    (waddr_p1_i),
        .wdata_p1_i    (wdata_p1_i),
        .write_hit_p1_o(write_hit_p1_o)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Reference model, index 0 = path A, 1 = path B
    bit            act [2];
    int            acc [2];
    int            natt[2];
    int            miss[2];
    bit            err [2];
    bit            cwe [2];
    logic [AW-1:0] caddr[2];
    logic [LW-1:0] hdata[2];
    logic [AW-1:0] e_raddr1, e_raddr2, e_waddr1;
    logic [LW-1:0] e_wdata1;

    task automatic check_eq(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [LW-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Non-idle from the cycle after accept up to the cycle before the response
    function automatic bit busy(input int p);
        return act[p] && (cyc > acc[p]) && (cyc <= acc[p] + 2 * natt[p]);
    endfunction

    function automatic bit strobe_now(input int p);
        return busy(p) && ((cyc - acc[p]) % 2 == 1);
    endfunction

    function automatic bit wait_now(input int p);
        return busy(p) && ((cyc - acc[p]) % 2 == 0);
    endfunction

    function automatic bit hit_now(input int p);
        return wait_now(p) && (((cyc - acc[p]) / 2 - 1) == miss[p]);
    endfunction

    function automatic bit rsp_now(input int p);
        return act[p] && (cyc == acc[p] + 2 * natt[p] + 1);
    endfunction

    function automatic bit same_line(input logic [AW-1:0] x, input logic [AW-1:0] y);
        return x[AW-1:OB] == y[AW-1:OB];
    endfunction

    task automatic clear_model();
        for (int p = 0; p < 2; p++) begin
            act[p] = 1'b0;
            cwe[p] = 1'b0;
        end
        e_raddr1 = '0;
        e_raddr2 = '0;
        e_waddr1 = '0;
        e_wdata1 = '0;
    endtask

    // One clock cycle: drive inputs and cache answers, then check all outputs
    task automatic step(input bit r, input bit av, input logic [AW-1:0] aa, input int am,
                        input bit bv, input bit bwe, input logic [AW-1:0] ba,
                        input logic [LW-1:0] bwd, input int bm);
        bit ea, eb, hz_a, hz_b;
        @(posedge clk);
        #1;
        cyc++;
        rst            = r;
        a_req_valid    = av;
        a_req_addr     = aa;
        b_req_valid    = bv;
        b_req_we       = bwe;
        b_req_addr     = ba;
        b_req_wdata    = bwd;
        read_hit_p1_o  = 1'($urandom());
        read_hit_p2_o  = 1'($urandom());
        write_hit_p1_o = 1'($urandom());
        rdata_p1_o     = rnd_line();
        rdata_p2_o     = rnd_line();
        if (wait_now(0)) begin
            read_hit_p1_o = hit_now(0);
            if (hit_now(0)) rdata_p1_o = hdata[0];
        end
        if (wait_now(1)) begin
            if (cwe[1]) begin
                write_hit_p1_o = hit_now(1);
            end else begin
                read_hit_p2_o = hit_now(1);
                if (hit_now(1)) rdata_p2_o = hdata[1];
            end
        end
        @(negedge clk);
        hz_a = (busy(1) && cwe[1] && same_line(caddr[1], aa)) ||
               (!busy(1) && bv && bwe && same_line(ba, aa));
        hz_b = bwe && busy(0) && same_line(caddr[0], ba);
        ea = !busy(0) && !hz_a;
        eb = !busy(1) && !hz_b;
        check_eq("a_req_ready", LW'(a_req_ready), LW'(ea));
        check_eq("b_req_ready", LW'(b_req_ready), LW'(eb));
        check_eq("re_p1", LW'(re_p1_i), LW'(strobe_now(0)));
        check_eq("re_p2", LW'(re_p2_i), LW'(strobe_now(1) && !cwe[1]));
        check_eq("we_p1", LW'(we_p1_i), LW'(strobe_now(1) && cwe[1]));
        check_eq("raddr_p1", LW'(raddr_p1_i), LW'(e_raddr1));
        check_eq("raddr_p2", LW'(raddr_p2_i), LW'(e_raddr2));
        check_eq("waddr_p1", LW'(waddr_p1_i), LW'(e_waddr1));
        check_eq("wdata_p1", wdata_p1_i, e_wdata1);
        check_eq("a_rsp_valid", LW'(a_rsp_valid), LW'(rsp_now(0)));
        check_eq("b_rsp_valid", LW'(b_rsp_valid), LW'(rsp_now(1)));
        if (rsp_now(0)) begin
            check_eq("a_rsp_data", a_rsp_data, err[0] ? '0 : hdata[0]);
            check_eq("a_rsp_err", LW'(a_rsp_err), LW'(err[0]));
        end
        if (rsp_now(1)) begin
            check_eq("b_rsp_data", b_rsp_data, (err[1] || cwe[1]) ? '0 : hdata[1]);
            check_eq("b_rsp_err", LW'(b_rsp_err), LW'(err[1]));
        end
        if (!r && av && ea) begin
            act[0]   = 1'b1;
            acc[0]   = cyc;
            miss[0]  = am;
            natt[0]  = (am > MR) ? MR + 1 : am + 1;
            err[0]   = (am > MR);
            caddr[0] = aa;
            cwe[0]   = 1'b0;
            hdata[0] = rnd_line();
            e_raddr1 = aa;
        end
        if (!r && bv && eb) begin
            act[1]   = 1'b1;
            acc[1]   = cyc;
            miss[1]  = bm;
            natt[1]  = (bm > MR) ? MR + 1 : bm + 1;
            err[1]   = (bm > MR);
            caddr[1] = ba;
            cwe[1]   = bwe;
            hdata[1] = rnd_line();
            if (bwe) begin
                e_waddr1 = ba;
                e_wdata1 = bwd;
            end else begin
                e_raddr2 = ba;
            end
        end
        if (r) clear_model();
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 1'b0, '0, 0, 1'b0, 1'b0, '0, '0, 0);
    endtask

    task automatic hold_reset(input int k);
        repeat (k) step(1'b1, 1'b0, '0, 0, 1'b0, 1'b0, '0, '0, 0);
    endtask

    initial begin
        logic [AW-1:0] ra, rb;
        a_req_valid = 1'b0; a_req_addr = '0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        read_hit_p1_o = 1'b0; read_hit_p2_o = 1'b0; write_hit_p1_o = 1'b0;
        rdata_p1_o = '0; rdata_p2_o = '0;
        clear_model();
        hold_reset(3);
        idle(2);

        // A read, hit on first attempt
        step(1'b0, 1'b1, 32'h100, 0, 1'b0, 1'b0, '0, '0, 0);
        idle(4);
        // B write, two misses then hit
        step(1'b0, 1'b0, '0, 0, 1'b1, 1'b1, 32'h200, {16{8'hA5}}, 2);
        idle(8);
        // A read that never hits: error after MR+1 attempts
        step(1'b0, 1'b1, 32'h180, MR + 1, 1'b0, 1'b0, '0, '0, 0);
        idle(10);
        // same-line A read vs B write in the same cycle; A held until it gets in
        step(1'b0, 1'b1, 32'h308, 0, 1'b1, 1'b1, 32'h300, {16{8'h5A}}, 1);
        repeat (7) step(1'b0, 1'b1, 32'h308, 0, 1'b0, 1'b0, '0, '0, 0);
        idle(6);
        // different lines run in parallel
        step(1'b0, 1'b1, 32'h310, 0, 1'b1, 1'b1, 32'h300, {16{8'h3C}}, 0);
        idle(5);
        // read-read to the same line
        step(1'b0, 1'b1, 32'h40, 0, 1'b1, 1'b0, 32'h44, '0, 0);
        idle(5);
        // reset while A waits on the cache, then a fresh request
        step(1'b0, 1'b1, 32'h500, 2, 1'b0, 1'b0, '0, '0, 0);
        idle(1);
        hold_reset(1);
        idle(2);
        step(1'b0, 1'b1, 32'h600, 0, 1'b0, 1'b0, '0, '0, 0);
        idle(5);

        // random traffic over a few lines so hazards are frequent
        for (int i = 0; i < 4000; i++) begin
            ra = 32'h1000 + AW'($urandom_range(0, 3) << 4) + AW'($urandom_range(0, 15));
            rb = 32'h1000 + AW'($urandom_range(0, 3) << 4) + AW'($urandom_range(0, 15));
            step(($urandom_range(0, 299) == 0), 1'($urandom()), ra, int'($urandom_range(0, MR + 1)),
                 1'($urandom()), 1'($urandom()), rb, rnd_line(), int'($urandom_range(0, MR + 1)));
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
